fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_controller.sv | 141 ++++++++++++++
 tb/tb_fetch_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSTR_BYTES);

    // Fetch sequencer states; at most one memory transaction is in flight.
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        FLUSH = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch controller.
//
// Handshakes: imem request is held (address stable) until imem_gnt_i is seen
// with imem_req_o high; the response is the single imem_rvalid_i pulse that
// follows. Decode transfer completes on a cycle where instr_valid_o and
// instr_ready_i are both high; while valid is high and ready is low,
// instr_o / instr_pc_o are held. A redirect wins over every other event in
// the cycle it is sampled, including a decode handshake.
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] pc_o,
    output fetch_state_e    state_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    logic            imem_req;
    logic            instr_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_next_seq;
    logic            unused_redirect_lsbs;

    // Targets are word aligned; the low two bits of the request are dropped.
    assign redirect_target      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Sequential PC step, modulo 2^32 so 0xFFFF_FFFC rolls over to zero.
    assign pc_next_seq = pc_q + PC_STEP;

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= BOOT;
            pc_q       <= {BOOT_ADDR[XLEN-1:2], 2'b00};
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Next-state, PC update and output decode for the fetch sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect_i) begin
                    pc_d = redirect_target;
                end
            end

            REQ: begin
                imem_req = 1'b1;
                if (redirect_i) begin
                    pc_d = redirect_target;
                    // A grant in the same cycle still owes a response that
                    // must be swallowed before the next request goes out.
                    state_d = imem_gnt_i ? FLUSH : REQ;
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = imem_rvalid_i ? REQ : FLUSH;
                end else if (imem_rvalid_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    pc_d       = pc_next_seq;
                    state_d    = VALID;
                end
            end

            VALID: begin
                instr_valid = 1'b1;
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (instr_ready_i) begin
                    state_d = REQ;
                end
            end

            FLUSH: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                end
                // The owed response is dropped whenever it arrives; leaving
                // on it even when a redirect lands in the same cycle avoids
                // waiting for a response that will never come.
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_req_o    = imem_req;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = instr_valid;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a randomized memory responder.
module tb_fetch_controller;
    import riscv_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_gnt_i;
    logic         imem_rvalid_i;
    logic [31:0]  imem_rdata_i;
    logic         instr_valid_o;
    logic         instr_ready_i;
    logic [31:0]  instr_o;
    logic [31:0]  instr_pc_o;
    logic [31:0]  pc_o;
    fetch_state_e state_o;

    fetch_controller #(.BOOT_ADDR(BOOT)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .pc_o          (pc_o),
        .state_o       (state_o)
    );

    // Clock: period 10, rising edges at 5, 15, ...
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the architectural instruction stream is simply
    // target, target+4, ... restarting at every redirect or reset.
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    int          hs_count = 0;
    int          hs_cyc[$];
    logic [31:0] hs_pc[$];
    int          cycle = 0;

    // Knobs for the responder / stimulus process.
    int          gnt_min = 0, gnt_max = 0, rsp_min = 1, rsp_max = 1;
    bit          ready_rand = 1'b0;
    logic        ready_fixed = 1'b1;
    int          ready_pct = 100;
    int          redir_pct = 0;
    bit          redir_pend = 1'b0;
    int          redir_mode = 0;     // 0: next cycle, 1: with grant, 2: with rvalid
    logic [31:0] redir_tgt = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] t);
        exp_q.delete();
        model_pc = {t[31:2], 2'b00};
        top_up();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endtask

    task automatic fire_redirect();
        redirect_i    = 1'b1;
        redirect_pc_i = redir_tgt;
        model_restart(redir_tgt);
        redir_pend    = 1'b0;
    endtask

    // Driver: memory responder, redirect and ready stimulus, just after each rising edge.
    initial begin
        bit          pend;
        int          rw, req_cnt, cur_gdly;
        logic [31:0] gaddr, t;
        pend = 0; rw = 0; req_cnt = 0; cur_gdly = 0; gaddr = '0;
        redirect_i = 0; redirect_pc_i = '0; imem_gnt_i = 0; imem_rvalid_i = 0;
        imem_rdata_i = '0; instr_ready_i = 1;
        forever begin
            @(posedge clk_i);
            #1;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            redirect_i    = 1'b0;
            if (!reset_i) begin
                pend = 0; req_cnt = 0;
                continue;
            end
            if (pend) begin
                if (rw == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(gaddr);
                    pend = 0;
                    if (redir_pend && redir_mode == 2) fire_redirect();
                end else begin
                    rw--;
                end
            end else if (imem_req_o) begin
                if (req_cnt == 0) cur_gdly = $urandom_range(gnt_min, gnt_max);
                if (req_cnt >= cur_gdly) begin
                    imem_gnt_i = 1'b1;
                    gaddr      = imem_addr_o;
                    pend       = 1;
                    rw         = $urandom_range(rsp_min, rsp_max) - 1;
                    req_cnt    = 0;
                    if (redir_pend && redir_mode == 1) fire_redirect();
                end else begin
                    req_cnt++;
                end
            end
            if (redir_pend && redir_mode == 0) begin
                fire_redirect();
            end else if (!redirect_i && redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
                t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : ($urandom & 32'h0000_FFFF);
                redirect_i    = 1'b1;
                redirect_pc_i = t;
                model_restart(t);
            end
            instr_ready_i = ready_rand ? ($urandom_range(0, 99) < ready_pct) : ready_fixed;
        end
    end

    // Monitor: protocol checks and scoreboard pops, on the falling edge.
    initial begin
        bit          have_prev;
        logic        pv, pr, prd, preq, pgnt;
        logic [31:0] pinstr, ppc, paddr;
        int          owed;
        logic [63:0] e;
        have_prev = 0; owed = 0;
        pv = 0; pr = 0; prd = 0; preq = 0; pgnt = 0; pinstr = '0; ppc = '0; paddr = '0;
        forever begin
            @(negedge clk_i);
            cycle++;
            if (!reset_i) begin
                have_prev = 0;
                owed = 0;
                continue;
            end
            chk("pc_align", {30'd0, pc_o[1:0]}, 32'd0);
            chk("addr_eq_pc", imem_addr_o, pc_o);
            if (have_prev && pv && !pr && !prd) begin
                chk("valid_hold", {31'd0, instr_valid_o}, 32'd1);
                chk("instr_hold", instr_o, pinstr);
                chk("instr_pc_hold", instr_pc_o, ppc);
            end
            if (have_prev && preq && !pgnt && !prd) begin
                chk("req_hold", {31'd0, imem_req_o}, 32'd1);
                chk("addr_hold", imem_addr_o, paddr);
            end
            if (owed > 0) chk("single_outstanding", {31'd0, imem_req_o}, 32'd0);
            if (imem_gnt_i && imem_req_o) owed++;
            if (imem_rvalid_i && owed > 0) owed--;
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                hs_count++;
                hs_cyc.push_back(cycle);
                hs_pc.push_back(instr_pc_o);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_instr");
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc_o, e[63:32]);
                    chk("instr", instr_o, e[31:0]);
                    top_up();
                end
            end
            pv = instr_valid_o; pr = instr_ready_i; prd = redirect_i;
            preq = imem_req_o; pgnt = imem_gnt_i;
            pinstr = instr_o; ppc = instr_pc_o; paddr = imem_addr_o;
            have_prev = 1;
        end
    end

    task automatic wait_hs(input int n, input int budget, input string name);
        int start, t;
        start = hs_count;
        t = 0;
        while (hs_count < start + n && t < budget) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        if (hs_count < start + n) fail_now({name, "_timeout"});
    endtask

    task automatic wait_state(input fetch_state_e s, input int budget, input string name);
        int t;
        t = 0;
        @(negedge clk_i);
        while (state_o != s && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        if (state_o != s) fail_now({name, "_timeout"});
    endtask

    task automatic wait_redirect_fired(input int budget);
        int t;
        t = 0;
        while (redir_pend && t < budget) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        if (redir_pend) fail_now("redirect_fire_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc_o, BOOT);
        chk({tag, "_addr"}, imem_addr_o, BOOT);
        chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'h0000_0013);
        chk({tag, "_instr_pc"}, instr_pc_o, 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'(BOOT));
    endtask

    // Main sequence of directed scenarios followed by a random soak.
    initial begin
        int          base;
        logic [31:0] v_instr, v_pc;
        int          t;
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check_reset_outputs("reset");
        model_restart(BOOT);
        @(negedge clk_i);
        reset_i = 1'b1;

        // Back-to-back fetches with zero wait states: 0x0, 0x4, 0x8 every 3 cycles.
        base = hs_count;
        wait_hs(3, 40, "seq3");
        if (hs_count >= base + 3) begin
            chk("seq_pc0", hs_pc[base], 32'h0);
            chk("seq_pc1", hs_pc[base + 1], 32'h4);
            chk("seq_pc2", hs_pc[base + 2], 32'h8);
            chk("spacing01", 32'(hs_cyc[base + 1] - hs_cyc[base]), 32'd3);
            chk("spacing12", 32'(hs_cyc[base + 2] - hs_cyc[base + 1]), 32'd3);
        end

        // Slow memory: grant after 4 cycles, response after 3.
        gnt_min = 4; gnt_max = 4; rsp_min = 3; rsp_max = 3;
        wait_hs(2, 60, "slow_mem");

        // Decode stalls for 5 cycles with an instruction presented.
        gnt_min = 0; gnt_max = 0; rsp_min = 1; rsp_max = 1;
        ready_fixed = 1'b0;
        @(posedge clk_i);
        #2;
        t = 0;
        @(negedge clk_i);
        while (!instr_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!instr_valid_o) fail_now("stall_valid_timeout");
        v_instr = instr_o;
        v_pc    = instr_pc_o;
        repeat (5) begin
            @(negedge clk_i);
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_instr", instr_o, v_instr);
            chk("stall_pc", instr_pc_o, v_pc);
            chk("stall_no_req", {31'd0, imem_req_o}, 32'd0);
        end
        ready_fixed = 1'b1;
        wait_hs(1, 10, "stall_release");

        // Redirect to 0x103 while waiting for a response.
        rsp_min = 3; rsp_max = 3;
        wait_state(WAIT, 20, "redir_wait");
        redir_mode = 0; redir_tgt = 32'h0000_0103; redir_pend = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("redir_wait_flush", 32'(state_o), 32'(FLUSH));
        wait_redirect_fired(5);
        base = hs_count;
        wait_hs(1, 30, "redir_wait_hs");
        if (hs_count > base) chk("redir_wait_pc", hs_pc[base], 32'h0000_0100);

        // Redirect coinciding with a grant.
        rsp_min = 1; rsp_max = 2; gnt_min = 0; gnt_max = 2;
        redir_mode = 1; redir_tgt = 32'h0000_0200; redir_pend = 1'b1;
        wait_redirect_fired(30);
        base = hs_count;
        wait_hs(1, 30, "redir_gnt_hs");
        if (hs_count > base) chk("redir_gnt_pc", hs_pc[base], 32'h0000_0200);

        // Redirect coinciding with read data valid.
        redir_mode = 2; redir_tgt = 32'h0000_0302; redir_pend = 1'b1;
        wait_redirect_fired(30);
        base = hs_count;
        wait_hs(1, 30, "redir_rvalid_hs");
        if (hs_count > base) chk("redir_rvalid_pc", hs_pc[base], 32'h0000_0300);

        // PC wraps from the top of the address space.
        gnt_min = 0; gnt_max = 0; rsp_min = 1; rsp_max = 1;
        redir_mode = 0; redir_tgt = 32'hFFFF_FFF8; redir_pend = 1'b1;
        wait_redirect_fired(10);
        base = hs_count;
        wait_hs(3, 40, "wrap_hs");
        if (hs_count >= base + 3) begin
            chk("wrap_pc0", hs_pc[base], 32'hFFFF_FFF8);
            chk("wrap_pc1", hs_pc[base + 1], 32'hFFFF_FFFC);
            chk("wrap_pc2", hs_pc[base + 2], 32'h0000_0000);
        end

        // Random soak: variable latencies, random ready, random redirects.
        gnt_min = 0; gnt_max = 3; rsp_min = 1; rsp_max = 3;
        ready_rand = 1'b1; ready_pct = 70; redir_pct = 4;
        base = hs_count;
        repeat (3000) @(posedge clk_i);
        redir_pct = 0; ready_rand = 1'b0; ready_fixed = 1'b1;
        repeat (20) @(posedge clk_i);
        n_cmp++;
        if (hs_count - base < 200) begin
            n_bad++;
            $display("FAIL soak_throughput: got %0d instructions, expected at least 200", hs_count - base);
        end

        // Asynchronous reset in the middle of a transaction.
        gnt_min = 0; gnt_max = 0; rsp_min = 5; rsp_max = 5;
        wait_state(WAIT, 30, "reset_wait");
        #2;
        reset_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk_i);
        rsp_min = 1; rsp_max = 1;
        model_restart(BOOT);
        @(negedge clk_i);
        reset_i = 1'b1;
        base = hs_count;
        wait_hs(2, 30, "post_reset_hs");
        if (hs_count >= base + 2) begin
            chk("post_reset_pc0", hs_pc[base], BOOT);
            chk("post_reset_pc1", hs_pc[base + 1], BOOT + 32'd4);
        end

        repeat (5) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
